// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the unified memory port arbiter.
package mem_port_arbiter_pkg;

    // Arbiter FSM states, 3-bit binary encoding.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_WAIT = 3'd1,
        D_WAIT = 3'd2,
        I_RESP = 3'd3,
        D_RESP = 3'd4
    } arb_state_e;

    // Decide whether the data port wins the grant in IDLE.
    // prio = 0 means the data port goes first on contention.
    function automatic logic pick_data(input logic ireq, input logic dreq,
                                       input logic prio, input logic fair);
        if (!dreq) return 1'b0;
        if (!ireq) return 1'b1;
        return fair ? !prio : 1'b1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Single-ported memory bus driven by the arbiter (master) towards the memory (slave).
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/port_resp_reg.sv
// Per-port response capture register: loads on enable, holds otherwise.
module port_resp_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture the memory response when this port's access completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data
// access, producing the pipeline stall signals.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int FAIR   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    mem_port_arbiter_if.master mem
);

    localparam logic FAIR_EN = (FAIR != 0);

    arb_state_e        state_q, state_d;
    logic              prio_q;
    logic              abort_q, abort_d;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              dreq;
    logic              grant, grant_d;
    logic              ld_i, ld_d;

    assign dreq = d_read | d_write;

    // Next-state logic, grant decision, fetch abort tracking and capture enables.
    always_comb begin
        state_d = state_q;
        abort_d = 1'b0;
        grant   = 1'b0;
        grant_d = 1'b0;
        ld_i    = 1'b0;
        ld_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (if_req || dreq) begin
                    grant   = 1'b1;
                    grant_d = pick_data(if_req, dreq, prio_q, FAIR_EN);
                    state_d = grant_d ? D_WAIT : I_WAIT;
                    // A flush in the grant cycle kills the fetch before it starts.
                    abort_d = !grant_d && if_flush;
                end
            end
            I_WAIT: begin
                abort_d = abort_q || if_flush;
                if (mem.mem_ready) begin
                    abort_d = 1'b0;
                    // An aborted fetch still finishes on the bus but is never returned.
                    if (abort_q || if_flush) begin
                        state_d = IDLE;
                    end else begin
                        ld_i    = 1'b1;
                        state_d = I_RESP;
                    end
                end
            end
            D_WAIT: begin
                if (mem.mem_ready) begin
                    ld_d    = !mem_we_q;
                    state_d = D_RESP;
                end
            end
            I_RESP, D_RESP: state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    // State, priority, abort flag and the registered memory request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            abort_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            abort_q <= abort_d;
            if (grant) begin
                prio_q      <= grant_d;
                mem_we_q    <= grant_d & d_write;
                mem_addr_q  <= grant_d ? d_addr : if_addr;
                mem_wdata_q <= grant_d ? d_wdata : '0;
            end
        end
    end

    assign mem.mem_en    = (state_q == I_WAIT) || (state_q == D_WAIT);
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

    assign if_stall = if_req & !((state_q == I_RESP) & !abort_q);
    assign d_stall  = dreq & (state_q != D_RESP);

    port_resp_reg #(.W(DATA_W)) u_i_resp (
        .clk (clk),
        .rst (rst),
        .ld  (ld_i),
        .d   (mem.mem_rdata),
        .q   (if_rdata)
    );

    port_resp_reg #(.W(DATA_W)) u_d_resp (
        .clk (clk),
        .rst (rst),
        .ld  (ld_d),
        .d   (mem.mem_rdata),
        .q   (d_rdata)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized stream checked against a transaction-level memory model.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req, if_flush, d_read, d_write;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [31:0] if_rdata, d_rdata;
    logic        if_stall, d_stall;

    // Second instance with FAIR=0 and a zero-wait memory.
    logic        if_req0, d_read0;
    logic [31:0] if_rdata0, d_rdata0;
    logic        if_stall0, d_stall0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FAIR(1)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_stall(if_stall),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_stall(d_stall),
        .mem(bus.master)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FAIR(0)) dut0 (
        .clk(clk), .rst(rst),
        .if_req(if_req0), .if_addr(32'h100), .if_flush(1'b0),
        .if_rdata(if_rdata0), .if_stall(if_stall0),
        .d_read(d_read0), .d_write(1'b0), .d_addr(32'h200), .d_wdata(32'h0),
        .d_rdata(d_rdata0), .d_stall(d_stall0),
        .mem(bus0.master)
    );

    assign bus0.mem_ready = bus0.mem_en;
    assign bus0.mem_rdata = 32'h1234_5678;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- memory responder (slave side) ----------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } grant_t;

    grant_t      glog[$];
    logic [31:0] memarr[logic [31:0]];
    int          lat_cfg = 0;
    int          wcnt = 0;
    int          unstable_cnt = 0;
    int          en_cycles = 0;
    grant_t      cur;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h3C3C_0000;
    endfunction

    always @(posedge clk) begin
        #2;
        if (bus.mem_en) begin
            en_cycles++;
            if (wcnt == 0) begin
                cur.we    = bus.mem_we;
                cur.addr  = bus.mem_addr;
                cur.wdata = bus.mem_wdata;
                glog.push_back(cur);
            end else if (bus.mem_we !== cur.we || bus.mem_addr !== cur.addr ||
                         bus.mem_wdata !== cur.wdata) begin
                unstable_cnt++;
            end
            if (wcnt >= lat_cfg) begin
                bus.mem_ready = 1'b1;
                if (bus.mem_we) begin
                    memarr[bus.mem_addr] = bus.mem_wdata;
                    bus.mem_rdata = $urandom;
                end else begin
                    bus.mem_rdata = memarr.exists(bus.mem_addr) ?
                                    memarr[bus.mem_addr] : init_val(bus.mem_addr);
                end
            end else begin
                bus.mem_ready = 1'b0;
                bus.mem_rdata = $urandom;
            end
            wcnt++;
        end else begin
            wcnt = 0;
            bus.mem_ready = 1'b0;
            bus.mem_rdata = $urandom;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] shadow[logic [31:0]];
    logic        m_prio;
    logic [31:0] m_if_rdata, m_d_rdata;

    function automatic logic [31:0] shadow_rd(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : init_val(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if_req = 1'b0; if_flush = 1'b0; d_read = 1'b0; d_write = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_prio = 1'b0;
        m_if_rdata = '0;
        m_d_rdata = '0;
    endtask

    // One transaction set, started at posedge+1 of a cycle in which the arbiter is IDLE.
    task automatic do_access(input bit fi, input bit fr, input bit fw,
                             input logic [31:0] ia, input logic [31:0] da,
                             input logic [31:0] wd, input int lat);
        bit          fd, d_first, i_done, d_done;
        int          i_exp_cyc, d_exp_cyc, n0, n;
        grant_t      exp_g[2];
        fd = fr | fw;
        d_first = fd && (!fi || !m_prio);
        n = 0;
        // Apply accesses in the order the arbiter must grant them.
        for (int k = 0; k < 2; k++) begin
            bit do_d;
            do_d = (k == 0) ? d_first : !d_first;
            if (do_d && fd) begin
                exp_g[n].we = fw; exp_g[n].addr = da; exp_g[n].wdata = fw ? wd : 32'h0;
                if (fw) shadow[da] = wd; else m_d_rdata = shadow_rd(da);
                n++;
                m_prio = 1'b1;
            end else if (!do_d && fi) begin
                exp_g[n].we = 1'b0; exp_g[n].addr = ia; exp_g[n].wdata = 32'h0;
                m_if_rdata = shadow_rd(ia);
                n++;
                m_prio = 1'b0;
            end
        end
        i_exp_cyc = (fi && fd && d_first) ? 2 * lat + 5 : lat + 2;
        d_exp_cyc = (fi && fd && !d_first) ? 2 * lat + 5 : lat + 2;
        n0 = glog.size();
        lat_cfg = lat;
        if_req = fi; if_addr = ia;
        d_read = fr; d_write = fw; d_addr = da; d_wdata = wd;
        i_done = !fi;
        d_done = !fd;
        for (int cyc = 0; cyc < 64 && !(i_done && d_done); cyc++) begin
            @(negedge clk);
            if (!i_done && !if_stall) begin
                chk("if_stall_low_cycle", cyc, i_exp_cyc);
                chk("if_rdata", if_rdata, m_if_rdata);
                i_done = 1'b1;
            end
            if (!d_done && !d_stall) begin
                chk("d_stall_low_cycle", cyc, d_exp_cyc);
                chk("d_rdata", d_rdata, m_d_rdata);
                d_done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (i_done) if_req = 1'b0;
            if (d_done) begin d_read = 1'b0; d_write = 1'b0; end
        end
        if (!(i_done && d_done)) chk("access_timeout", 32'd0, 32'd1);
        chk("grant_count", glog.size() - n0, n);
        if (glog.size() == n0 + n) begin
            for (int k = 0; k < n; k++) begin
                chk("grant_we", 32'(glog[n0+k].we), 32'(exp_g[k].we));
                chk("grant_addr", glog[n0+k].addr, exp_g[k].addr);
                if (exp_g[k].we) chk("grant_wdata", glog[n0+k].wdata, exp_g[k].wdata);
            end
        end
        chk("bus_stable", unstable_cnt, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, e0, dgr;
        bit found;
        logic [31:0] pool[8];
        if_addr = '0; d_addr = '0; d_wdata = '0;
        if_req0 = 1'b1; d_read0 = 1'b1;
        for (int k = 0; k < 8; k++) pool[k] = 32'h1000 + 32'(4 * k);
        do_reset();

        // Reset state.
        @(negedge clk);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_mem_en", 32'(bus.mem_en), 0);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_if_stall", 32'(if_stall), 0);
        chk("rst_d_stall", 32'(d_stall), 0);
        @(posedge clk);
        #1;

        // FAIR=0: with both held, only the data port is ever granted.
        dgr = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("fair0_if_stall", 32'(if_stall0), 1);
            if (bus0.mem_en) begin
                chk("fair0_addr", bus0.mem_addr, 32'h200);
                dgr++;
            end
            @(posedge clk);
            #1;
        end
        chk("fair0_dgrants", 32'(dgr > 2), 1);
        chk("fair0_d_rdata", d_rdata0, 32'h1234_5678);
        d_read0 = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 6 && !found; c++) begin
            @(negedge clk);
            if (bus0.mem_en && bus0.mem_addr == 32'h100) found = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("fair0_i_after_d", 32'(found), 1);
        if_req0 = 1'b0;

        // Fetch, memory ready in the second WAIT cycle.
        memarr[32'h10] = 32'h8C22_0004;
        shadow[32'h10] = 32'h8C22_0004;
        e0 = en_cycles;
        do_access(1, 0, 0, 32'h10, 32'h0, 32'h0, 1);
        chk("t1_mem_en_cycles", en_cycles - e0, 2);
        chk("t1_if_rdata", if_rdata, 32'h8C22_0004);

        // Zero-wait store.
        do_access(0, 0, 1, 32'h0, 32'h40, 32'hDEAD_BEEF, 0);
        chk("t2_mem_written", memarr[32'h40], 32'hDEAD_BEEF);

        // Contention under FAIR=1 from reset: D, I, D, I.
        do_reset();
        do_access(1, 1, 0, 32'h20, 32'h24, 32'h0, 0);
        do_access(1, 1, 0, 32'h28, 32'h2C, 32'h0, 1);

        // Flush in the second I_WAIT cycle, then a fresh fetch.
        lat_cfg = 3;
        n0 = glog.size();
        if_req = 1'b1; if_addr = 32'h80;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("t4_if_stall_high", 32'(if_stall), 1);
            chk("t4_if_rdata_held", if_rdata, m_if_rdata);
            @(posedge clk);
            #1;
            if (c == 1) if_flush = 1'b1;
            if (c == 2) begin if_flush = 1'b0; if_addr = 32'h84; end
            if (c == 4) lat_cfg = 0;
        end
        m_if_rdata = shadow_rd(32'h84);
        m_prio = 1'b0;
        found = 1'b0;
        for (int c = 6; c < 20 && !found; c++) begin
            @(negedge clk);
            if (!if_stall) begin
                chk("t4_refetch_cycle", c, 7);
                chk("t4_refetch_data", if_rdata, m_if_rdata);
                found = 1'b1;
            end
            @(posedge clk);
            #1;
            if (found) if_req = 1'b0;
        end
        chk("t4_refetch_done", 32'(found), 1);
        chk("t4_grants", glog.size() - n0, 2);
        if (glog.size() == n0 + 2) begin
            chk("t4_grant0_addr", glog[n0].addr, 32'h80);
            chk("t4_grant1_addr", glog[n0+1].addr, 32'h84);
        end

        // Read and write together: write wins.
        do_access(0, 1, 1, 32'h0, 32'h48, 32'hCAFE_0001, 1);
        chk("t6_mem_written", memarr[32'h48], 32'hCAFE_0001);

        // Reset in the middle of D_WAIT.
        lat_cfg = 5;
        d_read = 1'b1; d_addr = 32'h44;
        @(posedge clk);
        @(posedge clk);
        #4 rst = 1'b1;
        #1;
        chk("t5_mem_en", 32'(bus.mem_en), 0);
        chk("t5_mem_we", 32'(bus.mem_we), 0);
        chk("t5_mem_addr", bus.mem_addr, 0);
        chk("t5_mem_wdata", bus.mem_wdata, 0);
        chk("t5_if_rdata", if_rdata, 0);
        chk("t5_d_rdata", d_rdata, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        m_prio = 1'b0; m_if_rdata = '0; m_d_rdata = '0;
        do_access(0, 1, 0, 32'h0, 32'h44, 32'h0, 0);

        // Randomized stream.
        for (int it = 0; it < 40; it++) begin
            bit fi;
            int dk;
            fi = 1'($urandom_range(0, 1));
            dk = $urandom_range(0, 3);
            if (!fi && dk == 0) fi = 1'b1;
            do_access(fi, (dk == 1) || (dk == 3), dk >= 2,
                      pool[$urandom_range(0, 7)], pool[$urandom_range(0, 7)],
                      $urandom, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
